// File: rtl/chan_scan_mux.sv
// Registered N-channel data selector: direct mode picks a channel by sel_in,
// scan mode walks every channel autonomously, dwelling DWELL cycles on each.
module chan_scan_mux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int DWELL    = 4,
  parameter int CNT_W    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CHANNELS*WIDTH-1:0]   din,
  input  logic [SEL_W-1:0]            sel_in,
  input  logic                        mode,
  input  logic                        en,
  input  logic                        hold,
  output logic [WIDTH-1:0]            dout,
  output logic [SEL_W-1:0]            dout_ch,
  output logic                        dout_valid,
  output logic                        sel_err,
  output logic                        wrap
);

  localparam int               SLOTS    = 1 << SEL_W;
  localparam logic [SEL_W:0]   CH_LIMIT = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0] PTR_LAST = SEL_W'(CHANNELS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  typedef enum logic {DIRECT, SCAN} state_t;

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [CNT_W-1:0] cnt;
  logic             wrap_pend;
  logic [WIDTH-1:0] slot [SLOTS];
  logic             sel_ok;

  // Slots beyond CHANNELS read as zero so any sel_in indexes a defined entry
  for (genvar k = 0; k < SLOTS; k++) begin : g_slot
    if (k < CHANNELS) begin : g_live
      assign slot[k] = din[k*WIDTH +: WIDTH];
    end else begin : g_pad
      assign slot[k] = '0;
    end
  end

  assign sel_ok = {1'b0, sel_in} < CH_LIMIT;

  // wrap_pend delays the wrap pulse so it coincides with the first channel-0 sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= DIRECT;
      ptr        <= '0;
      cnt        <= '0;
      wrap_pend  <= 1'b0;
      dout       <= '0;
      dout_ch    <= '0;
      dout_valid <= 1'b0;
      sel_err    <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      wrap       <= 1'b0;
      if (en) begin
        if (!mode) begin
          state      <= DIRECT;
          ptr        <= '0;
          cnt        <= '0;
          wrap_pend  <= 1'b0;
          dout       <= sel_ok ? slot[sel_in] : '0;
          dout_ch    <= sel_in;
          dout_valid <= sel_ok;
          sel_err    <= !sel_ok;
        end else if (state == DIRECT) begin
          state      <= SCAN;
          ptr        <= '0;
          cnt        <= '0;
          wrap_pend  <= 1'b0;
          dout       <= slot[0];
          dout_ch    <= '0;
          dout_valid <= 1'b1;
          sel_err    <= 1'b0;
        end else begin
          dout       <= slot[ptr];
          dout_ch    <= ptr;
          dout_valid <= 1'b1;
          sel_err    <= 1'b0;
          if (!hold) begin
            wrap <= wrap_pend;
            if (cnt == CNT_LAST) begin
              cnt       <= '0;
              ptr       <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
              wrap_pend <= (ptr == PTR_LAST);
            end else begin
              cnt       <= cnt + 1'b1;
              wrap_pend <= 1'b0;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_chan_scan_mux.sv
// Scoreboard bench for chan_scan_mux: a 4-channel DWELL=2 instance and a
// 3-channel DWELL=1 instance share control inputs.
module tb_chan_scan_mux;

  localparam int W = 8;

  typedef struct packed {
    logic [1:0]   ch;
    logic [W-1:0] data;
    logic         valid;
    logic         err;
    logic         wrap;
  } obs_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [4*W-1:0] din;
  logic [3*W-1:0] din3;
  logic [1:0]     sel_in;
  logic           mode, en, hold;
  logic [W-1:0]   dout, dout3;
  logic [1:0]     dout_ch, dout_ch3;
  logic           dout_valid, sel_err, wrap;
  logic           dout_valid3, sel_err3, wrap3;

  obs_t obs, obs3, exp_v;
  obs_t exp_q[$];
  obs_t exp3_q[$];

  logic [W-1:0] ch_val  [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
  logic [W-1:0] ch3_val [3] = '{8'h11, 8'h22, 8'h33};

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign obs  = {dout_ch, dout, dout_valid, sel_err, wrap};
  assign obs3 = {dout_ch3, dout3, dout_valid3, sel_err3, wrap3};

  chan_scan_mux #(.WIDTH(W), .CHANNELS(4), .SEL_W(2), .DWELL(2), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .din(din), .sel_in(sel_in), .mode(mode), .en(en), .hold(hold),
    .dout(dout), .dout_ch(dout_ch), .dout_valid(dout_valid), .sel_err(sel_err), .wrap(wrap)
  );

  chan_scan_mux #(.WIDTH(W), .CHANNELS(3), .SEL_W(2), .DWELL(1), .CNT_W(16)) u_dut3 (
    .clk(clk), .rst(rst), .din(din3), .sel_in(sel_in), .mode(mode), .en(en), .hold(hold),
    .dout(dout3), .dout_ch(dout_ch3), .dout_valid(dout_valid3), .sel_err(sel_err3), .wrap(wrap3)
  );

  function automatic obs_t mk(int ch, logic [W-1:0] d, logic v, logic e, logic w);
    return {2'(ch), d, v, e, w};
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("ch=%0d data=%02h valid=%b err=%b wrap=%b", o.ch, o.data, o.valid, o.err, o.wrap);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; mode = 1'b0; hold = 1'b0; sel_in = 2'd0;
    din  = {ch_val[3], ch_val[2], ch_val[1], ch_val[0]};
    din3 = {ch3_val[2], ch3_val[1], ch3_val[0]};
    #1;
    checks++;
    if (obs !== mk(0, 8'h00, 0, 0, 0)) begin
      failures++;
      $display("[TB] FAIL reset_state: got %s expected %s", fmt(obs), fmt(mk(0, 8'h00, 0, 0, 0)));
    end
    checks++;
    if (obs3 !== mk(0, 8'h00, 0, 0, 0)) begin
      failures++;
      $display("[TB] FAIL reset_state3: got %s expected %s", fmt(obs3), fmt(mk(0, 8'h00, 0, 0, 0)));
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(mk(0, 8'h00, 0, 0, 0));
      exp3_q.push_back(mk(0, 8'h00, 0, 0, 0));
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("[TB] FAIL idle_after_reset %0d: got %s expected %s", i, fmt(obs), fmt(exp_v));
      end
      exp_v = exp3_q.pop_front();
      checks++;
      if (obs3 !== exp_v) begin
        failures++;
        $display("[TB] FAIL idle_after_reset3 %0d: got %s expected %s", i, fmt(obs3), fmt(exp_v));
      end
    end
  endtask

  task automatic test_direct();
    en = 1'b1; mode = 1'b0; hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sel_in = 2'(i);
      exp_q.push_back(mk(i, ch_val[i], 1, 0, 0));
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("[TB] FAIL direct_sel %0d: got %s expected %s", i, fmt(obs), fmt(exp_v));
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [1:0] sels [3] = '{2'd3, 2'd1, 2'd2};
    for (int i = 0; i < 3; i++) begin
      sel_in = sels[i];
      if (sels[i] == 2'd3) exp3_q.push_back(mk(3, 8'h00, 0, 1, 0));
      else                 exp3_q.push_back(mk(sels[i], ch3_val[sels[i]], 1, 0, 0));
      tick();
      exp_v = exp3_q.pop_front();
      checks++;
      if (obs3 !== exp_v) begin
        failures++;
        $display("[TB] FAIL out_of_range %0d: got %s expected %s", i, fmt(obs3), fmt(exp_v));
      end
    end
  endtask

  task automatic test_scan_dwell();
    int seq  [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    int seq3 [10] = '{0, 1, 2, 0, 1, 2, 0, 1, 2, 0};
    mode = 1'b1; hold = 1'b0; en = 1'b1;
    for (int i = -1; i < 10; i++) begin
      if (i < 0) begin
        exp_q.push_back(mk(0, ch_val[0], 1, 0, 0));
        exp3_q.push_back(mk(0, ch3_val[0], 1, 0, 0));
      end else begin
        exp_q.push_back(mk(seq[i], ch_val[seq[i]], 1, 0, i == 8));
        exp3_q.push_back(mk(seq3[i], ch3_val[seq3[i]], 1, 0, (seq3[i] == 0) && (i > 0)));
      end
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("[TB] FAIL scan_dwell %0d: got %s expected %s", i, fmt(obs), fmt(exp_v));
      end
      exp_v = exp3_q.pop_front();
      checks++;
      if (obs3 !== exp_v) begin
        failures++;
        $display("[TB] FAIL scan_dwell3 %0d: got %s expected %s", i, fmt(obs3), fmt(exp_v));
      end
    end
  endtask

  task automatic test_hold_enable();
    int           pre    [3] = '{1, 1, 2};
    logic [W-1:0] live   [3] = '{8'h5A, 8'h6B, 8'h7C};
    int           resume [3] = '{2, 3, 3};
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(mk(pre[i], ch_val[pre[i]], 1, 0, 0));
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("[TB] FAIL pre_hold %0d: got %s expected %s", i, fmt(obs), fmt(exp_v));
      end
    end
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din[2*W +: W] = live[i];
      exp_q.push_back(mk(2, live[i], 1, 0, 0));
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("[TB] FAIL hold %0d: got %s expected %s", i, fmt(obs), fmt(exp_v));
      end
    end
    en = 1'b0; mode = 1'b0; hold = 1'b0;
    din[2*W +: W] = 8'hEE;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(mk(2, 8'h7C, 0, 0, 0));
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("[TB] FAIL enable_freeze %0d: got %s expected %s", i, fmt(obs), fmt(exp_v));
      end
    end
    en = 1'b1; mode = 1'b1;
    din[2*W +: W] = ch_val[2];
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(mk(resume[i], ch_val[resume[i]], 1, 0, 0));
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("[TB] FAIL resume %0d: got %s expected %s", i, fmt(obs), fmt(exp_v));
      end
    end
  endtask

  task automatic test_mode_switch();
    int seq [7] = '{0, 0, 1, 1, 2, 2, 3};
    int tail [3] = '{0, 0, 1};
    // Pointer has just wrapped; leaving scan must drop the pending wrap pulse
    mode = 1'b0; sel_in = 2'd1;
    exp_q.push_back(mk(1, ch_val[1], 1, 0, 0));
    mode = 1'b0;
    tick();
    mode = 1'b1;
    exp_q.push_back(mk(0, ch_val[0], 1, 0, 0));
    tick();
    for (int i = 0; i < 2; i++) begin
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v && i == 1) begin
        failures++;
        $display("[TB] FAIL rescan_entry: got %s expected %s", fmt(obs), fmt(exp_v));
      end
    end
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(mk(seq[i], ch_val[seq[i]], 1, 0, 0));
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("[TB] FAIL mode_pre %0d: got %s expected %s", i, fmt(obs), fmt(exp_v));
      end
    end
    mode = 1'b0; sel_in = 2'd1;
    exp_q.push_back(mk(1, ch_val[1], 1, 0, 0));
    tick();
    exp_v = exp_q.pop_front();
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("[TB] FAIL mode_to_direct: got %s expected %s", fmt(obs), fmt(exp_v));
    end
    mode = 1'b1;
    exp_q.push_back(mk(0, ch_val[0], 1, 0, 0));
    tick();
    exp_v = exp_q.pop_front();
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("[TB] FAIL mode_to_scan: got %s expected %s", fmt(obs), fmt(exp_v));
    end
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(mk(tail[i], ch_val[tail[i]], 1, 0, 0));
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("[TB] FAIL mode_tail %0d: got %s expected %s", i, fmt(obs), fmt(exp_v));
      end
    end
  endtask

  task automatic test_async_reset();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== mk(0, 8'h00, 0, 0, 0)) begin
      failures++;
      $display("[TB] FAIL async_reset: got %s expected %s", fmt(obs), fmt(mk(0, 8'h00, 0, 0, 0)));
    end
    checks++;
    if (obs3 !== mk(0, 8'h00, 0, 0, 0)) begin
      failures++;
      $display("[TB] FAIL async_reset3: got %s expected %s", fmt(obs3), fmt(mk(0, 8'h00, 0, 0, 0)));
    end
    en = 1'b0; mode = 1'b0;
    #1;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(mk(0, 8'h00, 0, 0, 0));
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("[TB] FAIL post_reset_idle %0d: got %s expected %s", i, fmt(obs), fmt(exp_v));
      end
    end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_out_of_range();
    test_scan_dwell();
    test_hold_enable();
    test_mode_switch();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
